// File: rtl/keccak_absorb.sv
// ============================================================================
// keccak_absorb : Keccak message-absorb stage; owns the 1600-bit state and
//                 hands it to the round datapath with a start/done handshake.
// Revision      : 1.0
// ============================================================================
`default_nettype none

package keccak_pkg;
  localparam int N = 64;
  typedef logic [4:0][4:0][N-1:0] state;
endpackage

module keccak_absorb #(
  parameter int RATE_LANES = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init_i,
  input  logic [63:0]      lane_i,
  input  logic             lane_valid_i,
  input  logic             lane_last_i,
  output logic             lane_ready_o,
  output logic             perm_start_o,
  output keccak_pkg::state perm_state_o,
  input  logic             perm_done_i,
  input  keccak_pkg::state perm_state_i,
  output logic             digest_valid_o
);

  typedef enum logic [1:0] {
    ST_ABSORB = 2'd0,
    ST_PERM   = 2'd1,
    ST_DONE   = 2'd2
  } fsm_e;

  localparam logic [4:0] c_LAST_LANE = 5'(RATE_LANES - 1);

  fsm_e             r_fsm;
  keccak_pkg::state r_state;
  logic [4:0]       r_lane_cnt;
  logic             r_last;
  logic             r_start;
  logic             r_ready;
  logic             r_digest;

  logic             w_accept;
  logic             w_final;
  keccak_pkg::state w_absorb;

  // r_ready is only ever high in ST_ABSORB, so it doubles as the accept qualifier.
  assign w_accept = lane_valid_i & r_ready;
  assign w_final  = w_accept & (r_lane_cnt == c_LAST_LANE);

  generate
    for (genvar gy = 0; gy < 5; gy++) begin : g_row
      for (genvar gx = 0; gx < 5; gx++) begin : g_col
        localparam int c_IDX = gy * 5 + gx;
        if (c_IDX < RATE_LANES) begin : g_rate
          logic w_sel;
          assign w_sel = (r_lane_cnt == 5'(c_IDX));
          assign w_absorb[gy][gx] = w_sel ? (r_state[gy][gx] ^ lane_i) : r_state[gy][gx];
        end else begin : g_capacity
          assign w_absorb[gy][gx] = r_state[gy][gx];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm      <= ST_ABSORB;
      r_state    <= '0;
      r_lane_cnt <= '0;
      r_last     <= 1'b0;
      r_start    <= 1'b0;
      r_ready    <= 1'b0;
      r_digest   <= 1'b0;
    end else if (init_i) begin
      r_fsm      <= ST_ABSORB;
      r_state    <= '0;
      r_lane_cnt <= '0;
      r_last     <= 1'b0;
      r_start    <= 1'b0;
      r_ready    <= 1'b1;
      r_digest   <= 1'b0;
    end else begin
      case (r_fsm)
        ST_ABSORB: begin
          r_start  <= 1'b0;
          r_ready  <= 1'b1;
          r_digest <= 1'b0;
          if (w_accept) begin
            r_state <= w_absorb;
            if (w_final) begin
              r_lane_cnt <= '0;
              r_last     <= lane_last_i;
              r_start    <= 1'b1;
              r_ready    <= 1'b0;
              r_fsm      <= ST_PERM;
            end else begin
              r_lane_cnt <= r_lane_cnt + 5'd1;
            end
          end
        end
        ST_PERM: begin
          r_start <= 1'b0;
          if (perm_done_i) begin
            r_state <= perm_state_i;
            if (r_last) begin
              r_fsm    <= ST_DONE;
              r_digest <= 1'b1;
            end else begin
              r_fsm   <= ST_ABSORB;
              r_ready <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_start  <= 1'b0;
          r_ready  <= 1'b0;
          r_digest <= 1'b1;
        end
        default: begin
          r_fsm    <= ST_ABSORB;
          r_start  <= 1'b0;
          r_ready  <= 1'b0;
          r_digest <= 1'b0;
        end
      endcase
    end
  end

  assign lane_ready_o   = r_ready;
  assign perm_start_o   = r_start;
  assign perm_state_o   = r_state;
  assign digest_valid_o = r_digest;

endmodule

`default_nettype wire

// File: tb/tb_keccak_absorb.sv
// ============================================================================
// tb_keccak_absorb : directed bench with expected-state scoreboard queue.
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_keccak_absorb;
  import keccak_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance A: default rate (17 lanes)
  logic        a_rst_n, a_init, a_valid, a_last, a_ready, a_start, a_done, a_digest;
  logic [63:0] a_lane;
  state        a_pso, a_psi;
  // instance B: 9-lane rate
  logic        b_rst_n, b_init, b_valid, b_last, b_ready, b_start, b_done, b_digest;
  logic [63:0] b_lane;
  state        b_pso, b_psi;

  keccak_absorb u_dut_a (
    .clk(clk), .rst_n(a_rst_n), .init_i(a_init), .lane_i(a_lane),
    .lane_valid_i(a_valid), .lane_last_i(a_last), .lane_ready_o(a_ready),
    .perm_start_o(a_start), .perm_state_o(a_pso), .perm_done_i(a_done),
    .perm_state_i(a_psi), .digest_valid_o(a_digest)
  );

  keccak_absorb #(.RATE_LANES(9)) u_dut_b (
    .clk(clk), .rst_n(b_rst_n), .init_i(b_init), .lane_i(b_lane),
    .lane_valid_i(b_valid), .lane_last_i(b_last), .lane_ready_o(b_ready),
    .perm_start_o(b_start), .perm_state_o(b_pso), .perm_done_i(b_done),
    .perm_state_i(b_psi), .digest_valid_o(b_digest)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   a_starts = 0;
  state m;
  state mb;
  state q_exp[$];

  always @(posedge clk) if (a_start === 1'b1) a_starts++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input state obs, input state exp);
    bit found;
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      found = 1'b0;
      for (int y = 0; y < 5; y++)
        for (int x = 0; x < 5; x++)
          if (!found && obs[y][x] !== exp[y][x]) begin
            found = 1'b1;
            $error("FAIL %s: lane[%0d][%0d] observed %h expected %h",
                   tag, y, x, obs[y][x], exp[y][x]);
          end
      if (!found) $error("FAIL %s: state differs (X/Z)", tag);
    end
  endtask

  function automatic state plus1(input state s);
    state r;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        r[y][x] = s[y][x] + 64'd1;
    return r;
  endfunction

  function automatic state fill(input logic [63:0] v);
    state r;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        r[y][x] = v;
    return r;
  endfunction

  task automatic send_block(input logic [63:0] d[25], input logic fin_last,
                            input int last_lane, input bit gappy, input int n);
    int         lows;
    logic [2:0] yy, xx;
    lows = 0;
    for (int k = 0; k < n; k++) begin
      if (gappy) begin
        int g;
        g = $urandom_range(0, 2);
        repeat (g) begin
          a_valid = 1'b0;
          tick;
        end
      end
      a_valid = 1'b1;
      a_lane  = d[k];
      a_last  = (k == 16) ? fin_last : (k == last_lane);
      if (a_ready !== 1'b1) lows++;
      yy = 3'(k / 5);
      xx = 3'(k % 5);
      m[yy][xx] = m[yy][xx] ^ d[k];
      tick;
    end
    a_valid = 1'b0;
    a_last  = 1'b0;
    if (!gappy) chk64("no_bubbles", 64'(lows), 64'd0);
    if (n == 17) q_exp.push_back(m);
  endtask

  task automatic expect_start;
    int w;
    w = 0;
    while (a_start !== 1'b1 && w < 5) begin
      tick;
      w++;
    end
    chk64("start_latency", 64'(w), 64'd0);
    chk_state("absorbed_state", a_pso, q_exp.pop_front());
    chk64("ready_low_in_perm", 64'(a_ready), 64'd0);
    tick;
    chk64("start_one_cycle", 64'(a_start), 64'd0);
  endtask

  task automatic perm_a(input state ret, input logic fin);
    a_psi  = ret;
    a_done = 1'b1;
    q_exp.push_back(ret);
    tick;
    a_done = 1'b0;
    m = ret;
    chk_state("perm_return", a_pso, q_exp.pop_front());
    chk64("ready_after_perm", 64'(a_ready), 64'(!fin));
    chk64("digest_after_perm", 64'(a_digest), 64'(fin));
  endtask

  task automatic do_init;
    a_init = 1'b1;
    tick;
    a_init = 1'b0;
    m = '0;
  endtask

  initial begin
    logic [63:0] d[25];
    logic [63:0] e[25];
    logic [63:0] acc;
    int          s0;

    a_rst_n = 1'b0; a_init = 1'b0; a_valid = 1'b0; a_last = 1'b0;
    a_lane = '0; a_done = 1'b0; a_psi = '0;
    b_rst_n = 1'b0; b_init = 1'b0; b_valid = 1'b0; b_last = 1'b0;
    b_lane = '0; b_done = 1'b0; b_psi = '0;
    m = '0; mb = '0;

    repeat (2) tick;
    chk64("rst_ready", 64'(a_ready), 64'd0);
    chk64("rst_start", 64'(a_start), 64'd0);
    chk64("rst_digest", 64'(a_digest), 64'd0);
    chk_state("rst_state", a_pso, '0);
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
    tick;
    chk64("ready_after_release", 64'(a_ready), 64'd1);

    // single-block message, lanes 1..17
    for (int k = 0; k < 25; k++) d[k] = 64'(k + 1);
    s0 = a_starts;
    send_block(d, 1'b1, -1, 1'b0, 17);
    expect_start;
    chk64("lane00", a_pso[0][0], 64'h1);
    chk64("lane31", a_pso[3][1], 64'h11);
    acc = '0;
    for (int k = 17; k < 25; k++) acc = acc | a_pso[k / 5][k % 5];
    chk64("capacity_zero", acc, 64'd0);
    chk64("one_start_pulse", 64'(a_starts - s0), 64'd1);
    perm_a(fill(64'hA5A5_A5A5_A5A5_A5A5), 1'b1);
    tick;
    chk64("digest_holds", 64'(a_digest), 64'd1);
    do_init;
    chk_state("init_clears", a_pso, '0);
    chk64("init_ready", 64'(a_ready), 64'd1);
    chk64("init_digest", 64'(a_digest), 64'd0);

    // two-block message, permutation model = +1 per lane
    for (int k = 0; k < 25; k++) begin
      d[k] = {$urandom, $urandom};
      e[k] = {$urandom, $urandom};
    end
    s0 = a_starts;
    send_block(d, 1'b0, -1, 1'b0, 17);
    expect_start;
    perm_a(plus1(m), 1'b0);
    send_block(e, 1'b1, -1, 1'b0, 17);
    expect_start;
    perm_a(plus1(m), 1'b1);
    chk64("two_start_pulses", 64'(a_starts - s0), 64'd2);
    do_init;

    // gappy valid, last pulsed on lane 5 only
    for (int k = 0; k < 25; k++) d[k] = {$urandom, $urandom};
    send_block(d, 1'b0, 5, 1'b1, 17);
    expect_start;
    perm_a(plus1(m), 1'b0);
    do_init;

    // init mid-block at lane_cnt = 9
    for (int k = 0; k < 25; k++) d[k] = {$urandom, $urandom};
    send_block(d, 1'b0, -1, 1'b0, 9);
    do_init;
    chk_state("init_midblock_state", a_pso, '0);
    chk64("init_midblock_ready", 64'(a_ready), 64'd1);
    send_block(d, 1'b1, -1, 1'b0, 17);
    expect_start;
    // init coincident with done in PERM: result must be discarded
    a_init = 1'b1;
    a_done = 1'b1;
    a_psi  = fill(64'hFFFF_FFFF_FFFF_FFFF);
    tick;
    a_init = 1'b0;
    a_done = 1'b0;
    m = '0;
    chk_state("init_vs_done_state", a_pso, '0);
    chk64("init_vs_done_ready", 64'(a_ready), 64'd1);
    chk64("init_vs_done_digest", 64'(a_digest), 64'd0);
    repeat (3) tick;
    chk64("no_late_digest", 64'(a_digest), 64'd0);

    // asynchronous reset mid-cycle with perm_start high
    for (int k = 0; k < 25; k++) d[k] = {$urandom, $urandom};
    send_block(d, 1'b1, -1, 1'b0, 17);
    chk_state("absorbed_before_rst", a_pso, q_exp.pop_front());
    chk64("start_before_rst", 64'(a_start), 64'd1);
    #2;
    a_rst_n = 1'b0;
    #1;
    chk64("async_rst_start", 64'(a_start), 64'd0);
    chk64("async_rst_ready", 64'(a_ready), 64'd0);
    chk64("async_rst_digest", 64'(a_digest), 64'd0);
    chk_state("async_rst_state", a_pso, '0);
    @(posedge clk);
    #1;
    a_rst_n = 1'b1;
    m = '0;
    tick;
    chk64("ready_after_async_rst", 64'(a_ready), 64'd1);
    for (int k = 0; k < 25; k++) d[k] = {$urandom, $urandom};
    send_block(d, 1'b1, -1, 1'b0, 17);
    expect_start;
    perm_a(plus1(m), 1'b1);

    // 9-lane rate instance
    for (int k = 0; k < 25; k++) begin
      d[k] = {$urandom, $urandom};
      e[k] = {$urandom, $urandom};
    end
    for (int k = 0; k < 9; k++) begin
      if (k == 8) chk64("b_no_early_start", 64'(b_start), 64'd0);
      b_valid = 1'b1;
      b_lane  = d[k];
      b_last  = 1'b0;
      mb[k / 5][k % 5] = mb[k / 5][k % 5] ^ d[k];
      tick;
    end
    b_valid = 1'b0;
    chk64("b_start_after_lane8", 64'(b_start), 64'd1);
    chk64("b_ready_low", 64'(b_ready), 64'd0);
    chk_state("b_block1_state", b_pso, mb);
    b_psi  = fill(64'hFFFF_FFFF_FFFF_FFFF);
    b_done = 1'b1;
    tick;
    b_done = 1'b0;
    mb = b_psi;
    chk64("b_ready_next_block", 64'(b_ready), 64'd1);
    for (int k = 0; k < 9; k++) begin
      b_valid = 1'b1;
      b_lane  = e[k];
      b_last  = (k == 8);
      mb[k / 5][k % 5] = mb[k / 5][k % 5] ^ e[k];
      tick;
    end
    b_valid = 1'b0;
    b_last  = 1'b0;
    chk_state("b_block2_state", b_pso, mb);
    acc = '1;
    for (int k = 9; k < 25; k++) acc = acc & b_pso[k / 5][k % 5];
    chk64("b_capacity_untouched", acc, 64'hFFFF_FFFF_FFFF_FFFF);
    b_psi  = fill(64'h0123_4567_89AB_CDEF);
    b_done = 1'b1;
    tick;
    b_done = 1'b0;
    chk64("b_digest", 64'(b_digest), 64'd1);
    chk_state("b_final_state", b_pso, fill(64'h0123_4567_89AB_CDEF));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
